// File: rtl/traffic_phase_ctrl.sv
// N-road round-robin traffic-light sequencer: green/yellow/all-red phases timed in ticks,
// with emergency pre-emption that diverts the rotation to a requested road and holds it green.
module traffic_phase_ctrl #(
    parameter int NUM_ROADS    = 4,
    parameter int GREEN_TICKS  = 10,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int CNT_W        = 8,
    localparam int IDX_W       = $clog2(NUM_ROADS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic                   emerg_req,
    input  logic [IDX_W-1:0]       emerg_road,
    output logic                   emerg_ack,
    output logic [2*NUM_ROADS-1:0] road_state,
    output logic [IDX_W-1:0]       active_road,
    output logic                   phase_done
);

    typedef enum logic [1:0] {GREEN, YELLOW, ALLRED, EMERG} state_e;

    localparam logic [1:0]       LS_GREEN  = 2'b11;
    localparam logic [1:0]       LS_YELLOW = 2'b10;
    localparam logic [1:0]       LS_RED    = 2'b01;
    localparam logic [IDX_W-1:0] LAST_ROAD = IDX_W'(NUM_ROADS - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [IDX_W-1:0]         active_q, active_d;
    logic                     pend_q, pend_d;
    logic [IDX_W-1:0]         tgt_q, tgt_d;
    logic [2*NUM_ROADS-1:0]   road_state_q, road_state_d;
    logic                     ack_q, ack_d;
    logic                     done_q, done_d;

    logic                     emerg_vld;
    logic                     lat_pend;
    logic [IDX_W-1:0]         lat_tgt;
    logic [IDX_W-1:0]         next_road;
    logic                     enter;

    assign emerg_vld = emerg_req && ({1'b0, emerg_road} < (IDX_W+1)'(NUM_ROADS));
    // A request seen on the very edge that ends the clearance still steers the next green.
    assign lat_pend  = pend_q | emerg_vld;
    assign lat_tgt   = emerg_vld ? emerg_road : tgt_q;
    assign next_road = (active_q == LAST_ROAD) ? '0 : active_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        active_d = active_q;
        pend_d   = pend_q;
        tgt_d    = tgt_q;
        enter    = 1'b0;
        case (state_q)
            GREEN: begin
                if (emerg_vld && emerg_road == active_q) begin
                    // own road requested: freeze the green
                end else if (emerg_vld) begin
                    pend_d  = 1'b1;
                    tgt_d   = emerg_road;
                    state_d = YELLOW;
                    count_d = '0;
                end else if (tick) begin
                    if (count_q == CNT_W'(GREEN_TICKS - 1)) begin
                        state_d = YELLOW;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            YELLOW: begin
                pend_d = lat_pend;
                tgt_d  = lat_tgt;
                if (tick) begin
                    if (count_q == CNT_W'(YELLOW_TICKS - 1)) begin
                        count_d = '0;
                        if (ALLRED_TICKS == 0) enter = 1'b1;
                        else                   state_d = ALLRED;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ALLRED: begin
                pend_d = lat_pend;
                tgt_d  = lat_tgt;
                if (tick) begin
                    if (count_q == CNT_W'(ALLRED_TICKS - 1)) begin
                        count_d = '0;
                        enter   = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            EMERG: begin
                if (!emerg_req) begin
                    state_d = YELLOW;
                    count_d = '0;
                end
            end
            default: state_d = GREEN;
        endcase

        if (enter) begin
            state_d  = lat_pend ? EMERG : GREEN;
            active_d = lat_pend ? lat_tgt : next_road;
            pend_d   = 1'b0;
        end

        // Light outputs are decoded from the next state so they change on the transition edge.
        road_state_d = '0;
        for (int i = 0; i < NUM_ROADS; i++) begin
            if (state_d != ALLRED && IDX_W'(i) == active_d)
                road_state_d[2*i +: 2] = (state_d == YELLOW) ? LS_YELLOW : LS_GREEN;
            else
                road_state_d[2*i +: 2] = LS_RED;
        end
        ack_d  = (state_d == EMERG);
        done_d = enter;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= GREEN;
            count_q      <= '0;
            active_q     <= '0;
            pend_q       <= 1'b0;
            tgt_q        <= '0;
            ack_q        <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NUM_ROADS; i++)
                road_state_q[2*i +: 2] <= (i == 0) ? LS_GREEN : LS_RED;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            tgt_q        <= tgt_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            road_state_q <= road_state_d;
        end
    end

    assign emerg_ack   = ack_q;
    assign road_state  = road_state_q;
    assign active_road = active_q;
    assign phase_done  = done_q;

endmodule
